// File: rtl/pipe_ctrl_chain_if.sv
// Bundle of control, payload and status signals between the hazard/branch
// logic and the pipeline register chain.
interface pipe_ctrl_chain_if #(
  parameter int DATA_W   = 32,
  parameter int N_STAGES = 4,
  parameter int CNT_W    = 16
);
  logic                         en;
  logic                         in_valid;
  logic [DATA_W-1:0]            in_data;
  logic                         stall;
  logic [N_STAGES-1:0]          flush;
  logic                         clr_cnt;
  logic [N_STAGES-1:0]          stage_valid;
  logic [N_STAGES*DATA_W-1:0]   stage_data;
  logic                         out_valid;
  logic [DATA_W-1:0]            out_data;
  logic [CNT_W-1:0]             bubble_cnt;
  logic [CNT_W-1:0]             flush_cnt;

  modport master (
    output en, in_valid, in_data, stall, flush, clr_cnt,
    input  stage_valid, stage_data, out_valid, out_data, bubble_cnt, flush_cnt
  );

  modport slave (
    input  en, in_valid, in_data, stall, flush, clr_cnt,
    output stage_valid, stage_data, out_valid, out_data, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// Pipeline register chain with per-stage valid bits, global enable,
// load-use stall with bubble injection, per-stage flush and saturating
// bubble/flush performance counters.
module pipe_ctrl_chain #(
  parameter int DATA_W      = 32,
  parameter int N_STAGES    = 4,
  parameter int STALL_STAGE = 1,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                arst_n,
  pipe_ctrl_chain_if.slave    bus
);

  // Reject configurations the chain cannot represent.
  if (N_STAGES < 2 || STALL_STAGE < 0 || STALL_STAGE >= N_STAGES) begin : g_bad_cfg
    $error("pipe_ctrl_chain: illegal N_STAGES/STALL_STAGE combination");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]   data_q [N_STAGES];
  logic [DATA_W-1:0]   data_d [N_STAGES];
  logic [CNT_W-1:0]    bubble_q, bubble_d;
  logic [CNT_W-1:0]    flushc_q, flushc_d;

  // Next state of every stage: flush beats stall hold/bubble beats advance.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (bus.en) begin
      for (int i = 0; i < N_STAGES; i++) begin
        if (bus.flush[i]) begin
          valid_d[i] = 1'b0;
          data_d[i]  = '0;
        end else if (bus.stall && i <= STALL_STAGE) begin
          valid_d[i] = valid_q[i];
          data_d[i]  = data_q[i];
        end else if (bus.stall && i == STALL_STAGE + 1) begin
          valid_d[i] = 1'b0;
          data_d[i]  = '0;
        end else if (i == 0) begin
          valid_d[i] = bus.in_valid;
          data_d[i]  = bus.in_data;
        end else begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end
    end
  end

  // Next counter values: clear wins over increment, increments saturate.
  always_comb begin
    bubble_d = bubble_q;
    flushc_d = flushc_q;
    if (bus.en) begin
      if (bus.clr_cnt) begin
        bubble_d = '0;
        flushc_d = '0;
      end else begin
        if (bus.stall && bubble_q != CNT_MAX) begin
          bubble_d = bubble_q + 1'b1;
        end
        if ((|bus.flush) && flushc_q != CNT_MAX) begin
          flushc_d = flushc_q + 1'b1;
        end
      end
    end
  end

  // State registers; reset clears valid bits, payloads and counters at once.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q  <= '0;
      data_q   <= '{default: '0};
      bubble_q <= '0;
      flushc_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      bubble_q <= bubble_d;
      flushc_q <= flushc_d;
    end
  end

  // Flatten the stage payloads onto the output bus.
  always_comb begin
    bus.stage_data = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      bus.stage_data[i*DATA_W +: DATA_W] = data_q[i];
    end
  end

  assign bus.stage_valid = valid_q;
  assign bus.out_valid   = valid_q[N_STAGES-1];
  assign bus.out_data    = data_q[N_STAGES-1];
  assign bus.bubble_cnt  = bubble_q;
  assign bus.flush_cnt   = flushc_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: a vector table on a 4-stage chain,
// plus hand sequences for counter saturation (whole-chain stall, 4-bit
// counters) and asynchronous reset.
module tb_pipe_ctrl_chain;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 32-bit payload, 4 stages, stall holds stages 0..1.
  pipe_ctrl_chain_if #(.DATA_W(32), .N_STAGES(4), .CNT_W(16)) bus_a ();
  pipe_ctrl_chain #(.DATA_W(32), .N_STAGES(4), .STALL_STAGE(1), .CNT_W(16))
    dut_a (.clk(clk), .arst_n(arst_n), .bus(bus_a));

  // Second instance: 4-bit counters, stall holds the whole chain.
  pipe_ctrl_chain_if #(.DATA_W(8), .N_STAGES(3), .CNT_W(4)) bus_b ();
  pipe_ctrl_chain #(.DATA_W(8), .N_STAGES(3), .STALL_STAGE(2), .CNT_W(4))
    dut_b (.clk(clk), .arst_n(arst_n), .bus(bus_b));

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic        en;
    logic        iv;
    logic [31:0] d;
    logic        st;
    logic [3:0]  fl;
    logic        clr;
    logic [3:0]  ev;
    logic [3:0][31:0] es;
    logic [15:0] eb;
    logic [15:0] ef;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(logic en, logic iv, logic [31:0] d, logic st,
                              logic [3:0] fl, logic clr, logic [3:0] ev,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                              logic [31:0] e3, logic [15:0] eb, logic [15:0] ef);
    vec_t v;
    v.en = en; v.iv = iv; v.d = d; v.st = st; v.fl = fl; v.clr = clr;
    v.ev = ev; v.es[0] = e0; v.es[1] = e1; v.es[2] = e2; v.es[3] = e3;
    v.eb = eb; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic iv, input logic [31:0] d,
                         input logic st, input logic [3:0] fl, input logic clr);
    bus_a.en = en; bus_a.in_valid = iv; bus_a.in_data = d;
    bus_a.stall = st; bus_a.flush = fl; bus_a.clr_cnt = clr;
  endtask

  task automatic drive_b(input logic en, input logic iv, input logic [7:0] d,
                         input logic st, input logic clr);
    bus_b.en = en; bus_b.in_valid = iv; bus_b.in_data = d;
    bus_b.stall = st; bus_b.flush = '0; bus_b.clr_cnt = clr;
  endtask

  task automatic chk_b(input string tag, input logic [2:0] ev, input logic [23:0] ed,
                       input logic [3:0] eb);
    chk({tag, " b.valid"}, 128'(bus_b.stage_valid), 128'(ev));
    chk({tag, " b.data"},  128'(bus_b.stage_data),  128'(ed));
    chk({tag, " b.bubble"}, 128'(bus_b.bubble_cnt), 128'(eb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Vector table for instance A, applied from reset.
    //             en iv d      st fl       clr ev       s0     s1     s2     s3     bub fl
    vecs[0]  = mk(1, 1, 32'hA1, 0, 4'b0000, 0, 4'b0001, 32'hA1, 32'h0,  32'h0,  32'h0,  0, 0);
    vecs[1]  = mk(1, 1, 32'hA2, 0, 4'b0000, 0, 4'b0011, 32'hA2, 32'hA1, 32'h0,  32'h0,  0, 0);
    vecs[2]  = mk(1, 1, 32'hA3, 0, 4'b0000, 0, 4'b0111, 32'hA3, 32'hA2, 32'hA1, 32'h0,  0, 0);
    vecs[3]  = mk(1, 1, 32'hA4, 0, 4'b0000, 0, 4'b1111, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 0, 0);
    vecs[4]  = mk(1, 1, 32'h0A, 0, 4'b0000, 0, 4'b1111, 32'h0A, 32'hA4, 32'hA3, 32'hA2, 0, 0);
    vecs[5]  = mk(1, 1, 32'h0B, 0, 4'b0000, 0, 4'b1111, 32'h0B, 32'h0A, 32'hA4, 32'hA3, 0, 0);
    vecs[6]  = mk(1, 1, 32'h0C, 0, 4'b0000, 0, 4'b1111, 32'h0C, 32'h0B, 32'h0A, 32'hA4, 0, 0);
    vecs[7]  = mk(1, 1, 32'h0D, 0, 4'b0000, 0, 4'b1111, 32'h0D, 32'h0C, 32'h0B, 32'h0A, 0, 0);
    vecs[8]  = mk(1, 1, 32'hEE, 1, 4'b0000, 0, 4'b1011, 32'h0D, 32'h0C, 32'h0,  32'h0B, 1, 0);
    vecs[9]  = mk(1, 1, 32'h0E, 0, 4'b0000, 0, 4'b0111, 32'h0E, 32'h0D, 32'h0C, 32'h0,  1, 0);
    vecs[10] = mk(1, 1, 32'h0A, 0, 4'b0000, 0, 4'b1111, 32'h0A, 32'h0E, 32'h0D, 32'h0C, 1, 0);
    vecs[11] = mk(1, 1, 32'h0B, 0, 4'b0000, 0, 4'b1111, 32'h0B, 32'h0A, 32'h0E, 32'h0D, 1, 0);
    vecs[12] = mk(1, 1, 32'h0C, 0, 4'b0000, 0, 4'b1111, 32'h0C, 32'h0B, 32'h0A, 32'h0E, 1, 0);
    vecs[13] = mk(1, 1, 32'h0D, 0, 4'b0000, 0, 4'b1111, 32'h0D, 32'h0C, 32'h0B, 32'h0A, 1, 0);
    vecs[14] = mk(1, 1, 32'hEE, 1, 4'b0011, 0, 4'b1000, 32'h0,  32'h0,  32'h0,  32'h0B, 2, 1);
    vecs[15] = mk(0, 1, 32'hFF, 1, 4'b1111, 1, 4'b1000, 32'h0,  32'h0,  32'h0,  32'h0B, 2, 1);
    vecs[16] = mk(0, 1, 32'hFF, 1, 4'b1111, 1, 4'b1000, 32'h0,  32'h0,  32'h0,  32'h0B, 2, 1);
    vecs[17] = mk(0, 1, 32'hFF, 1, 4'b1111, 1, 4'b1000, 32'h0,  32'h0,  32'h0,  32'h0B, 2, 1);
    vecs[18] = mk(1, 0, 32'h55, 0, 4'b0100, 1, 4'b0000, 32'h55, 32'h0,  32'h0,  32'h0,  0, 0);
    vecs[19] = mk(1, 1, 32'h66, 0, 4'b1000, 0, 4'b0001, 32'h66, 32'h55, 32'h0,  32'h0,  0, 1);

    drive_a(1, 0, 0, 0, 4'b0000, 0);
    drive_b(1, 0, 0, 0, 0);

    // Reset state while arst_n is held low.
    #12;
    chk("reset a.valid",  128'(bus_a.stage_valid), 128'(0));
    chk("reset a.data",   128'(bus_a.stage_data),  128'(0));
    chk("reset a.bubble", 128'(bus_a.bubble_cnt),  128'(0));
    chk("reset a.flush",  128'(bus_a.flush_cnt),   128'(0));
    chk_b("reset", 3'b000, 24'h0, 4'd0);
    arst_n = 1'b1;

    // Table-driven sequence on instance A.
    for (int v = 0; v < 20; v++) begin
      drive_a(vecs[v].en, vecs[v].iv, vecs[v].d, vecs[v].st, vecs[v].fl, vecs[v].clr);
      step();
      chk($sformatf("vec%0d valid", v), 128'(bus_a.stage_valid), 128'(vecs[v].ev));
      for (int s = 0; s < 4; s++)
        chk($sformatf("vec%0d s%0d", v, s), 128'(bus_a.stage_data[s*32 +: 32]), 128'(vecs[v].es[s]));
      chk($sformatf("vec%0d out_valid", v), 128'(bus_a.out_valid), 128'(vecs[v].ev[3]));
      chk($sformatf("vec%0d out_data", v),  128'(bus_a.out_data),  128'(vecs[v].es[3]));
      chk($sformatf("vec%0d bubble", v),    128'(bus_a.bubble_cnt), 128'(vecs[v].eb));
      chk($sformatf("vec%0d flushcnt", v),  128'(bus_a.flush_cnt),  128'(vecs[v].ef));
    end
    drive_a(1, 0, 0, 0, 4'b0000, 0);

    // Instance B: fill with 11,22,33, then whole-chain stall for 20 edges.
    drive_b(1, 1, 8'h11, 0, 0); step();
    drive_b(1, 1, 8'h22, 0, 0); step();
    drive_b(1, 1, 8'h33, 0, 0); step();
    chk_b("fill", 3'b111, 24'h112233, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      drive_b(1, 1, 8'h99, 1, 0);
      step();
      chk_b($sformatf("sat%0d", k), 3'b111, 24'h112233, (k > 15) ? 4'd15 : 4'(k));
    end
    drive_b(1, 1, 8'h99, 1, 1); step();
    chk_b("sat clr", 3'b111, 24'h112233, 4'd0);
    drive_b(1, 1, 8'h44, 0, 0); step();
    chk_b("resume", 3'b111, 24'h223344, 4'd0);

    // Instance A: one stall edge, then fill with 71..74 so the chain is full.
    drive_a(1, 1, 32'h70, 1, 4'b0000, 0); step();
    for (int k = 1; k <= 4; k++) begin
      drive_a(1, 1, 32'h70 + k, 0, 4'b0000, 0);
      step();
    end
    chk("prerst valid",  128'(bus_a.stage_valid), 128'(4'b1111));
    chk("prerst data",   128'(bus_a.stage_data),  128'h00000071_00000072_00000073_00000074);
    chk("prerst bubble", 128'(bus_a.bubble_cnt),  128'(1));
    chk("prerst flush",  128'(bus_a.flush_cnt),   128'(1));

    // Asynchronous reset between edges: state clears with no clock edge.
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst valid",  128'(bus_a.stage_valid), 128'(0));
    chk("arst data",   128'(bus_a.stage_data),  128'(0));
    chk("arst bubble", 128'(bus_a.bubble_cnt),  128'(0));
    chk("arst flush",  128'(bus_a.flush_cnt),   128'(0));
    chk("arst outv",   128'(bus_a.out_valid),   128'(0));
    drive_a(1, 1, 32'h88, 0, 4'b0000, 0);
    #1;
    arst_n = 1'b1;
    step();
    chk("post valid", 128'(bus_a.stage_valid), 128'(4'b0001));
    chk("post data",  128'(bus_a.stage_data),  128'h00000000_00000000_00000000_00000088);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_chain.md
Name: pipe_ctrl_chain

Overview:
Parametrised chain of pipeline registers with per-stage valid bits, global enable, a load-use stall with bubble injection, and per-stage flush. It replaces the hand-instantiated per-signal pipeline registers between IF/ID/EX/MEM/WB with one block that the core's hazard and branch logic can stall and flush. It also carries saturating bubble and flush counters for performance debug.

Parameters:
DATA_W, 32, width of the payload carried by each stage (a packed bundle of the datapath and control fields).
N_STAGES, 4, number of register stages (at least 2).
STALL_STAGE, 1, index of the last stage held during stall (0 to N_STAGES-1).
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  main clock, rising edge.
arst_n  in  1  asynchronous active-low reset.
en  in  1  global enable; 0 freezes all state, including the counters.
in_valid  in  1  valid bit of the incoming payload.
in_data  in  DATA_W  incoming payload, loaded into stage 0.
stall  in  1  load-use stall request.
flush  in  N_STAGES  per-stage flush; bit i kills stage i.
clr_cnt  in  1  synchronous clear of both counters.
stage_valid  out  N_STAGES  valid bit of each stage; bit i is stage i.
stage_data  out  N_STAGES*DATA_W  payload of each stage; stage i occupies bits [i*DATA_W +: DATA_W].
out_valid  out  1  equal to stage_valid[N_STAGES-1].
out_data  out  DATA_W  equal to the payload of the last stage.
bubble_cnt  out  CNT_W  number of enabled stall cycles, saturating.
flush_cnt  out  CNT_W  number of enabled cycles with any flush bit set, saturating.

Behaviour:
- Single clock domain. Asynchronous active-low reset clears every stage_valid bit, every stage payload and both counters to 0, immediately and without a clock edge. Release of reset is synchronous to clk.
- All state updates occur on the rising edge of clk, and only when en=1. When en=0, every register holds, and stall, flush and clr_cnt are ignored.
- Normal advance (en=1, stall=0, no flush): stage 0 loads {in_valid, in_data}; stage i loads stage i-1. Latency from in_data to out_data is N_STAGES edges.
- Stall (en=1, stall=1):
  - stages 0..STALL_STAGE hold their valid bit and payload;
  - stage STALL_STAGE+1, if it exists, loads a bubble (valid=0, payload=0);
  - stages above STALL_STAGE+1 advance normally;
  - if STALL_STAGE=N_STAGES-1, the whole chain holds and no bubble is inserted.
- in_data is not captured while stage 0 is held; the upstream source must keep its PC/fetch stable.
- Flush (en=1, flush[i]=1): stage i loads valid=0, payload=0 at the edge.
- Priority per stage: flush, then stall hold/bubble, then normal advance. Simultaneous stall and flush are legal and resolved stage by stage.
- Invalid payloads advance like valid ones; the block never drops or reorders valid entries except under flush or bubble.
- bubble_cnt: +1 on each edge with en=1 and stall=1, including when STALL_STAGE=N_STAGES-1.
- flush_cnt: +1 on each edge with en=1 and any flush bit set. A single cycle counts once regardless of how many bits are set.
- Both counters saturate at all-ones and never wrap.
- clr_cnt=1 with en=1 zeroes both counters at the edge, taking priority over an increment in the same cycle.
- All outputs are driven directly from registers, with no combinational path from input to output.
- Illegal configurations (N_STAGES<2, STALL_STAGE>=N_STAGES) fail elaboration.

Test Plan:
1. Fill (DATA_W=32, N_STAGES=4, STALL_STAGE=1): after reset, drive in_valid=1 with in_data=0xA1, 0xA2, 0xA3, 0xA4 on four consecutive edges -> stage_valid=4'b1111, out_data=0xA1, stage 0 payload=0xA4.
2. Stall from a full chain s0..s3 = 0xD, 0xC, 0xB, 0xA with stall=1 for one edge -> s0=0xD, s1=0xC, s2=(valid 0, payload 0), s3=0xB, bubble_cnt=1. Deasserting stall at the next edge -> s2=0xC.
3. stall=1 together with flush=4'b0011 from the same full chain -> s0 and s1 valid 0 / payload 0, s2 bubble, s3=0xB, bubble_cnt=1, flush_cnt=1.
4. en=0 while stall=1, flush=4'b1111 and clr_cnt=1 for 3 edges -> every stage, valid bit and counter unchanged.
5. Saturation with CNT_W=4: hold stall=1 for 20 edges -> bubble_cnt=15. Then assert stall=1 and clr_cnt=1 on the same edge -> bubble_cnt=0.
6. Drop arst_n between clock edges while the chain is full and both counters are non-zero -> stage_valid=0, all payloads 0 and both counters 0 before the next edge. After release, the first edge loads in_data into stage 0.
